// File: rtl/game_timer_ctrl_if.sv
// rtl/game_timer_ctrl_if.sv - button, counter-chain and status signals of the game timer control stage
interface game_timer_ctrl_if;
   logic       pb_start_raw;
   logic       pb_clear_raw;
   logic       chain_cout;
   logic       cnt_en;
   logic       pb_clear_op;
   logic       running;
   logic       done;
   logic [1:0] state;

   // master drives the buttons and the chain carry-out; slave is the control stage
   modport master (
      output pb_start_raw, pb_clear_raw, chain_cout,
      input  cnt_en, pb_clear_op, running, done, state
   );
   modport slave (
      input  pb_start_raw, pb_clear_raw, chain_cout,
      output cnt_en, pb_clear_op, running, done, state
   );
endinterface

// File: rtl/game_timer_ctrl.sv
// rtl/game_timer_ctrl.sv - button debounce, pulse generation and IDLE/RUN/PAUSE/DONE timer control
module game_timer_ctrl #(
   parameter int TICK_DIV = 50_000_000,
   parameter int DB_DIV   = 100_000,
   parameter int DB_LEN   = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   game_timer_ctrl_if.slave io
);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DB_DIV > 1) ? $clog2(DB_DIV) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DB_DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_RUN   = 2'b01,
      S_PAUSE = 2'b10,
      S_DONE  = 2'b11
   } state_t;

   // bit 0 carries the start button, bit 1 the clear button
   logic [1:0]        sync1;
   logic [1:0]        sync2;
   logic [DW-1:0]     db_cnt;
   logic              db_strobe;
   logic [DB_LEN-1:0] sh_start;
   logic [DB_LEN-1:0] sh_clear;
   logic [1:0]        lvl_q;
   logic [1:0]        lvl_nxt;
   logic [1:0]        pulse_q;
   logic              start_p;
   logic              clear_p;

   state_t            state_q;
   state_t            state_d;
   logic [TW-1:0]     pre_q;
   logic [TW-1:0]     pre_d;
   logic              tick_last;

   // two-flop synchronisers for the asynchronous raw buttons
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= {io.pb_clear_raw, io.pb_start_raw};
         sync2 <= sync1;
      end
   end

   assign db_strobe = (db_cnt == DB_LAST);

   // sample prescaler: one strobe every DB_DIV cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db_cnt <= '0;
      end else if (db_strobe) begin
         db_cnt <= '0;
      end else begin
         db_cnt <= db_cnt + DW'(1);
      end
   end

   // debounce history: shift the synchronised level in on each strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_start <= '0;
         sh_clear <= '0;
      end else if (db_strobe) begin
         sh_start <= {sh_start[DB_LEN-2:0], sync2[0]};
         sh_clear <= {sh_clear[DB_LEN-2:0], sync2[1]};
      end
   end

   // debounced level changes only on a full run of equal samples
   always_comb begin
      lvl_nxt = lvl_q;
      if (&sh_start) begin
         lvl_nxt[0] = 1'b1;
      end else if (~|sh_start) begin
         lvl_nxt[0] = 1'b0;
      end
      if (&sh_clear) begin
         lvl_nxt[1] = 1'b1;
      end else if (~|sh_clear) begin
         lvl_nxt[1] = 1'b0;
      end
   end

   // registered debounced levels and their one-cycle rising-edge pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_q   <= '0;
         pulse_q <= '0;
      end else begin
         lvl_q   <= lvl_nxt;
         pulse_q <= lvl_nxt & ~lvl_q;
      end
   end

   assign start_p   = pulse_q[0];
   assign clear_p   = pulse_q[1];
   assign tick_last = (pre_q == TICK_LAST);

   // state and tick prescaler registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         pre_q   <= '0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
      end
   end

   // next state: clear beats everything, end of game beats a start press
   always_comb begin
      state_d = state_q;
      pre_d   = pre_q;
      if (clear_p) begin
         state_d = S_IDLE;
         pre_d   = '0;
      end else begin
         if (state_q == S_RUN) begin
            pre_d = tick_last ? '0 : pre_q + TW'(1);
         end
         case (state_q)
            S_IDLE: begin
               if (start_p) begin
                  state_d = S_RUN;
                  pre_d   = '0;
               end
            end
            S_RUN: begin
               if (io.chain_cout) begin
                  state_d = S_DONE;
               end else if (start_p) begin
                  state_d = S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (start_p) begin
                  state_d = S_RUN;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign io.cnt_en      = (state_q == S_RUN) && tick_last && !clear_p;
   assign io.pb_clear_op = clear_p;
   assign io.running     = (state_q == S_RUN);
   assign io.done        = (state_q == S_DONE);
   assign io.state       = state_q;

endmodule

// File: tb/tb_game_timer_ctrl.sv
// tb/tb_game_timer_ctrl.sv - randomized self-checking bench for game_timer_ctrl
module tb_game_timer_ctrl;
   localparam int TD  = 5;
   localparam int DBD = 2;
   localparam int DBL = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic st_raw = 1'b0;
   logic cl_raw = 1'b0;
   logic end_arm = 1'b0;

   int n_checks = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   game_timer_ctrl_if bus ();

   assign bus.pb_start_raw = st_raw;
   assign bus.pb_clear_raw = cl_raw;
   // counter chain stand-in: carries out on the tick where the bench arms end of game
   assign bus.chain_cout   = bus.cnt_en & end_arm;

   game_timer_ctrl #(.TICK_DIV(TD), .DB_DIV(DBD), .DB_LEN(DBL)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io    (bus)
   );

   // reference model
   int m_edge;
   int m_state;
   int m_pre;
   bit m_cnt_en, m_sp, m_cp;
   bit st_d1, st_d2, cl_d1, cl_d2;
   bit st_lvl, st_lvl_p, cl_lvl, cl_lvl_p;
   bit st_smp[$];
   bit cl_smp[$];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic bit all_eq(input bit q[$], input bit v);
      foreach (q[i]) if (q[i] != v) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit next_lvl(input bit q[$], input bit cur);
      if (all_eq(q, 1'b1)) return 1'b1;
      if (all_eq(q, 1'b0)) return 1'b0;
      return cur;
   endfunction

   task automatic model_reset();
      m_edge = 0; m_state = 0; m_pre = 0;
      m_cnt_en = 0; m_sp = 0; m_cp = 0;
      st_d1 = 0; st_d2 = 0; cl_d1 = 0; cl_d2 = 0;
      st_lvl = 0; st_lvl_p = 0; cl_lvl = 0; cl_lvl_p = 0;
      st_smp.delete(); cl_smp.delete();
      for (int i = 0; i < DBL; i++) begin
         st_smp.push_back(1'b0);
         cl_smp.push_back(1'b0);
      end
   endtask

   // advance the model across one rising edge
   task automatic model_edge();
      bit ce, sp, cp, nst, ncl;
      ce = m_cnt_en; sp = m_sp; cp = m_cp;
      if (cp) begin
         m_state = 0;
         m_pre = 0;
      end else begin
         if (m_state == 1) m_pre = (m_pre + 1) % TD;
         case (m_state)
            0: if (sp) begin m_state = 1; m_pre = 0; end
            1: if (ce && end_arm) m_state = 3; else if (sp) m_state = 2;
            2: if (sp) m_state = 1;
            default: ;
         endcase
      end
      // button seen by the sampler is the one driven two edges earlier
      if (m_edge % DBD == DBD - 1) begin
         st_smp.push_back(st_d2); void'(st_smp.pop_front());
         cl_smp.push_back(cl_d2); void'(cl_smp.pop_front());
      end
      m_sp = st_lvl & ~st_lvl_p;
      m_cp = cl_lvl & ~cl_lvl_p;
      nst = next_lvl(st_smp, st_lvl);
      ncl = next_lvl(cl_smp, cl_lvl);
      st_lvl_p = st_lvl; st_lvl = nst;
      cl_lvl_p = cl_lvl; cl_lvl = ncl;
      st_d2 = st_d1; st_d1 = st_raw;
      cl_d2 = cl_d1; cl_d1 = cl_raw;
      m_cnt_en = (m_state == 1) && (m_pre == TD - 1) && !m_cp;
      m_edge++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk("state", 32'(bus.state), 32'(m_state));
      chk("cnt_en", 32'(bus.cnt_en), 32'(m_cnt_en));
      chk("pb_clear_op", 32'(bus.pb_clear_op), 32'(m_cp));
      chk("running", 32'(bus.running), 32'(m_state == 1));
      chk("done", 32'(bus.done), 32'(m_state == 3));
   endtask

   task automatic press(input bit s, input bit c, input int hold, input int gap,
                        output int clr_cycles);
      clr_cycles = 0;
      st_raw = s;
      cl_raw = c;
      repeat (hold) begin
         tick();
         if (bus.pb_clear_op) clr_cycles++;
      end
      st_raw = 1'b0;
      cl_raw = 1'b0;
      repeat (gap) begin
         tick();
         if (bus.pb_clear_op) clr_cycles++;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      st_raw = 1'b0; cl_raw = 1'b0; end_arm = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      int nc;
      int kind, hold, gap;

      do_reset();
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_cnt_en", 32'(bus.cnt_en), 32'd0);

      // bouncing start button, then a solid hold
      for (int i = 0; i < 40; i++) begin
         st_raw = 1'(i % 2);
         tick();
      end
      st_raw = 1'b1;
      repeat (20) tick();
      chk("bounce_run", 32'(bus.state), 32'd1);
      st_raw = 1'b0;
      repeat (20) tick();
      chk("still_run", 32'(bus.state), 32'd1);

      // pause and resume
      press(1'b1, 1'b0, 16, 16, nc);
      chk("paused", 32'(bus.state), 32'd2);
      repeat (10) tick();
      press(1'b1, 1'b0, 16, 7, nc);
      chk("resumed", 32'(bus.state), 32'd1);

      // end of game
      end_arm = 1'b1;
      for (int k = 0; k < 20 && m_state != 3; k++) tick();
      end_arm = 1'b0;
      chk("done_state", 32'(bus.state), 32'd3);
      chk("done_flag", 32'(bus.done), 32'd1);
      repeat (10) tick();
      press(1'b1, 1'b0, 16, 16, nc);
      chk("done_ignores_start", 32'(bus.state), 32'd3);
      press(1'b0, 1'b1, 16, 16, nc);
      chk("clr_from_done", 32'(bus.state), 32'd0);
      chk("clr_width_done", 32'(nc), 32'd1);

      // clear from RUN and from PAUSE
      press(1'b1, 1'b0, 16, 16, nc);
      press(1'b0, 1'b1, 16, 16, nc);
      chk("clr_from_run", 32'(bus.state), 32'd0);
      chk("clr_width_run", 32'(nc), 32'd1);
      press(1'b1, 1'b0, 16, 16, nc);
      press(1'b1, 1'b0, 16, 16, nc);
      chk("pause_before_clr", 32'(bus.state), 32'd2);
      press(1'b0, 1'b1, 16, 16, nc);
      chk("clr_from_pause", 32'(bus.state), 32'd0);
      chk("clr_width_pause", 32'(nc), 32'd1);

      // start and clear together from IDLE
      press(1'b1, 1'b1, 16, 16, nc);
      chk("simul_idle", 32'(bus.state), 32'd0);
      chk("simul_clr_width", 32'(nc), 32'd1);

      // random presses, glitches and end-of-game arming
      for (int r = 0; r < 150; r++) begin
         kind = $urandom_range(0, 5);
         hold = (kind == 3) ? $urandom_range(1, 3) : $urandom_range(1, 18);
         gap  = $urandom_range(1, 14);
         end_arm = ($urandom_range(0, 9) == 0);
         case (kind)
            0, 3: press(1'b1, 1'b0, hold, gap, nc);
            1:    press(1'b0, 1'b1, hold, gap, nc);
            2:    press(1'b1, 1'b1, hold, gap, nc);
            default: press(1'b0, 1'b0, hold, gap, nc);
         endcase
      end
      end_arm = 1'b0;

      // asynchronous reset while running
      press(1'b0, 1'b1, 16, 16, nc);
      press(1'b1, 1'b0, 16, 6, nc);
      chk("pre_reset_run", 32'(bus.state), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_state", 32'(bus.state), 32'd0);
      chk("async_cnt_en", 32'(bus.cnt_en), 32'd0);
      chk("async_clear_op", 32'(bus.pb_clear_op), 32'd0);
      chk("async_running", 32'(bus.running), 32'd0);
      chk("async_done", 32'(bus.done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      press(1'b1, 1'b0, 16, 16, nc);
      chk("run_after_reset", 32'(bus.state), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
